// File: rtl/adder_share_ctrl.sv
// ---------------------------------------------------------------------------
// adder_share_ctrl
//   Time-shares one external 4-bit combinational adder between NREQ
//   requesters. A round-robin arbiter picks one pending requester. Its
//   operands are registered onto the adder inputs and held for LAT cycles.
//   The settled {co,sum} is then captured and offered as a valid/ready
//   response tagged with the requester index.
//
//   Parameters
//     NREQ  number of requesters (2..8)
//     LAT   adder settling time in clk cycles (>=1)
//
//   Ports
//     clk, rst_n           clock, asynchronous active-low reset
//     req                  per-requester pending flag (level)
//     a_in, b_in, ci_in    per-requester operands, nibble i at [4i+3:4i]
//     gnt                  one-hot, combinational, one-cycle: operands taken
//     add_a/add_b/add_ci   registered operands to the shared adder
//     add_sum/add_co       result from the shared adder
//     rsp_valid/rsp_ready  response handshake
//     rsp_id               index of the requester owning the response
//     rsp_sum/rsp_co       registered result
//     busy                 an operation is in flight (HOLD or RESP)
// ---------------------------------------------------------------------------
module adder_share_ctrl #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned LAT  = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req,
  input  logic [4*NREQ-1:0]        a_in,
  input  logic [4*NREQ-1:0]        b_in,
  input  logic [NREQ-1:0]          ci_in,
  output logic [NREQ-1:0]          gnt,
  output logic [3:0]               add_a,
  output logic [3:0]               add_b,
  output logic                     add_ci,
  input  logic [3:0]               add_sum,
  input  logic                     add_co,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic [3:0]               rsp_sum,
  output logic                     rsp_co,
  output logic                     busy
);

  localparam int unsigned IDW  = $clog2(NREQ);
  localparam int unsigned CNTW = (LAT > 1) ? $clog2(LAT) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HOLD = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]      state_q,   state_d;
  logic [IDW-1:0]  ptr_q,     ptr_d;
  logic [CNTW-1:0] cnt_q,     cnt_d;
  logic [3:0]      add_a_q,   add_a_d;
  logic [3:0]      add_b_q,   add_b_d;
  logic            add_ci_q,  add_ci_d;
  logic [IDW-1:0]  rsp_id_q,  rsp_id_d;
  logic [3:0]      rsp_sum_q, rsp_sum_d;
  logic            rsp_co_q,  rsp_co_d;

  logic [NREQ-1:0] gnt_c;
  logic            any_req;
  logic [IDW-1:0]  win;
  logic [IDW:0]    cand;
  logic [3:0]      win_a;
  logic [3:0]      win_b;
  logic            win_ci;

  // Round-robin pick: first set req scanning upward from ptr+1, wrapping at NREQ.
  // ptr+k never exceeds 2*NREQ-1, so one conditional subtract is the modulo.
  always_comb begin
    any_req = 1'b0;
    win     = '0;
    cand    = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = {1'b0, ptr_q} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NREQ)) begin
        cand = cand - (IDW+1)'(NREQ);
      end
      if (!any_req && req[IDW'(cand)]) begin
        any_req = 1'b1;
        win     = IDW'(cand);
      end
    end
  end

  // Operand mux for the winning requester.
  always_comb begin
    win_a  = '0;
    win_b  = '0;
    win_ci = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (win == IDW'(i)) begin
        win_a  = a_in[4*i +: 4];
        win_b  = b_in[4*i +: 4];
        win_ci = ci_in[i];
      end
    end
  end

  // Next-state and grant logic.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    add_a_d   = add_a_q;
    add_b_d   = add_b_q;
    add_ci_d  = add_ci_q;
    rsp_id_d  = rsp_id_q;
    rsp_sum_d = rsp_sum_q;
    rsp_co_d  = rsp_co_q;
    gnt_c     = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          gnt_c    = NREQ'(1) << win;
          add_a_d  = win_a;
          add_b_d  = win_b;
          add_ci_d = win_ci;
          rsp_id_d = win;
          ptr_d    = win;
          cnt_d    = CNTW'(LAT - 1);
          state_d  = ST_HOLD;
        end
      end
      ST_HOLD: begin
        // Operands stay frozen; sample only once the full settling time has elapsed.
        if (cnt_q == '0) begin
          rsp_sum_d = add_sum;
          rsp_co_d  = add_co;
          state_d   = ST_RESP;
        end else begin
          cnt_d = cnt_q - CNTW'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ptr_q     <= IDW'(NREQ - 1);
      cnt_q     <= '0;
      add_a_q   <= '0;
      add_b_q   <= '0;
      add_ci_q  <= 1'b0;
      rsp_id_q  <= '0;
      rsp_sum_q <= '0;
      rsp_co_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      add_a_q   <= add_a_d;
      add_b_q   <= add_b_d;
      add_ci_q  <= add_ci_d;
      rsp_id_q  <= rsp_id_d;
      rsp_sum_q <= rsp_sum_d;
      rsp_co_q  <= rsp_co_d;
    end
  end

  // gnt is combinational; mask it while reset is held so no grant is claimed.
  assign gnt       = rst_n ? gnt_c : '0;
  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign add_ci    = add_ci_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_co    = rsp_co_q;
  assign rsp_valid = (state_q == ST_RESP);
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_adder_share_ctrl.sv
// ---------------------------------------------------------------------------
// tb_adder_share_ctrl
//   Randomized and directed bench for adder_share_ctrl (NREQ=4, LAT=3).
//   The shared adder is modelled as producing a wrong value until its inputs
//   have been stable for LAT cycles. A transaction-level model predicts
//   grants, adder inputs, busy and responses every cycle.
// ---------------------------------------------------------------------------
module tb_adder_share_ctrl;

  localparam int unsigned NREQ = 4;
  localparam int unsigned LAT  = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req;
  logic [4*NREQ-1:0] a_in;
  logic [4*NREQ-1:0] b_in;
  logic [NREQ-1:0]   ci_in;
  logic [NREQ-1:0]   gnt;
  logic [3:0]        add_a, add_b;
  logic              add_ci;
  logic [3:0]        add_sum;
  logic              add_co;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [1:0]        rsp_id;
  logic [3:0]        rsp_sum;
  logic              rsp_co;
  logic              busy;

  int n_chk  = 0;
  int n_fail = 0;

  adder_share_ctrl #(.NREQ(NREQ), .LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .a_in(a_in), .b_in(b_in), .ci_in(ci_in),
    .gnt(gnt), .add_a(add_a), .add_b(add_b), .add_ci(add_ci),
    .add_sum(add_sum), .add_co(add_co), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_co(rsp_co), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Shared adder: correct only after inputs held LAT cycles, otherwise corrupted.
  int         stab = 0;
  logic [3:0] pa, pb;
  logic       pci;
  logic [4:0] r5;
  always @(negedge clk) begin
    if (add_a === pa && add_b === pb && add_ci === pci) stab++;
    else stab = 1;
    pa  = add_a;
    pb  = add_b;
    pci = add_ci;
    r5  = 5'({1'b0, add_a} + {1'b0, add_b} + 5'(add_ci));
    if (stab >= int'(LAT)) {add_co, add_sum} = r5;
    else                   {add_co, add_sum} = r5 ^ 5'h15;
  end

  // Transaction model: idle or active with an age counted from the grant cycle.
  bit              m_active;
  int              m_age, m_ptr, m_id, m_win, m_j;
  bit              m_found;
  logic [3:0]      m_a, m_b;
  logic            m_ci;
  logic [NREQ-1:0] m_gnt;
  logic [NREQ-1:0] last_gnt;
  int              m_res;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_active = 0; m_age = 0; m_ptr = NREQ - 1; m_id = 0;
      m_a = '0; m_b = '0; m_ci = 1'b0; last_gnt = '0;
    end else begin
      m_gnt = '0; m_found = 0; m_win = 0;
      if (!m_active) begin
        for (int k = 1; k <= int'(NREQ); k++) begin
          m_j = (m_ptr + k) % NREQ;
          if (!m_found && req[m_j]) begin m_found = 1; m_win = m_j; end
        end
      end
      if (m_found) m_gnt[m_win] = 1'b1;
      chk("gnt", 32'(gnt), 32'(m_gnt));
      chk("add_a", 32'(add_a), 32'(m_a));
      chk("add_b", 32'(add_b), 32'(m_b));
      chk("add_ci", 32'(add_ci), 32'(m_ci));
      chk("busy", 32'(busy), 32'(m_active));
      chk("rsp_valid", 32'(rsp_valid), 32'(m_active && m_age > int'(LAT)));
      if (m_active && m_age > int'(LAT)) begin
        m_res = int'(m_a) + int'(m_b) + int'(m_ci);
        chk("rsp_id", 32'(rsp_id), 32'(m_id));
        chk("rsp_result", 32'({rsp_co, rsp_sum}), 32'(m_res));
      end
      if (m_found) begin
        m_active = 1; m_age = 1; m_ptr = m_win; m_id = m_win;
        m_a = a_in[4*m_win +: 4]; m_b = b_in[4*m_win +: 4]; m_ci = ci_in[m_win];
      end else if (m_active) begin
        if (m_age > int'(LAT) && rsp_ready) m_active = 0;
        else m_age++;
      end
      last_gnt = gnt;
    end
  end

  task automatic set_op(input int i, input logic [3:0] a, input logic [3:0] b, input logic c);
    a_in[4*i +: 4] = a;
    b_in[4*i +: 4] = b;
    ci_in[i]       = c;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    req   = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // One directed operation with literal expectations on grant, latency and result.
  task automatic run_one(input int idx, input logic [3:0] a, input logic [3:0] b,
                         input logic c, input bit change, input logic [4:0] exp);
    int lat;
    @(posedge clk); #1;
    req = '0; req[idx] = 1'b1; set_op(idx, a, b, c);
    @(negedge clk);
    chk("dir_gnt", 32'(gnt), 32'(1 << idx));
    @(posedge clk); #1;
    req[idx] = 1'b0;
    if (change) set_op(idx, ~a, ~b, ~c);
    lat = 1;
    @(negedge clk);
    while (!rsp_valid && lat < 40) begin @(negedge clk); lat++; end
    chk("dir_latency", 32'(lat), 32'(LAT + 1));
    chk("dir_id", 32'(rsp_id), 32'(idx));
    chk("dir_result", 32'({rsp_co, rsp_sum}), 32'(exp));
    @(negedge clk);
    chk("dir_pulse", 32'(rsp_valid), 32'd0);
  endtask

  int g_cyc[5];
  int g_idx[5];
  int exp_order[5] = '{0, 1, 2, 3, 0};

  initial begin
    int ng, cyc, lat;
    rst_n = 1'b0; req = '0; rsp_ready = 1'b1;
    a_in = 16'($urandom); b_in = 16'($urandom); ci_in = 4'($urandom);
    apply_reset();
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_id", 32'(rsp_id), 32'd0);
    chk("rst_result", 32'({rsp_co, rsp_sum}), 32'd0);
    chk("rst_add", 32'({add_ci, add_b, add_a}), 32'd0);

    run_one(2, 4'h3, 4'h4, 1'b1, 0, 5'd8);
    run_one(2, 4'hF, 4'hF, 1'b1, 0, 5'h1F);
    run_one(1, 4'h0, 4'h0, 1'b0, 0, 5'h00);
    run_one(1, 4'h5, 4'h6, 1'b0, 1, 5'd11);

    // Response stalled for 6 cycles with another request waiting.
    @(posedge clk); #1;
    rsp_ready = 1'b0; req = 4'b0001; set_op(0, 4'h9, 4'h8, 1'b1);
    @(negedge clk);
    chk("stall_gnt0", 32'(gnt), 32'b0001);
    @(posedge clk); #1;
    req = 4'b1000; set_op(3, 4'h2, 4'h2, 1'b0);
    lat = 0;
    @(negedge clk);
    while (!rsp_valid && lat < 40) begin @(negedge clk); lat++; end
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk);
      chk("stall_valid", 32'(rsp_valid), 32'd1);
      chk("stall_nognt", 32'(gnt), 32'd0);
      chk("stall_result", 32'({rsp_co, rsp_sum}), 32'd18);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(negedge clk);
    chk("accept_nognt", 32'(gnt), 32'd0);
    @(negedge clk);
    chk("after_accept_gnt", 32'(gnt), 32'b1000);
    @(posedge clk); #1 req = '0;
    repeat (8) @(posedge clk);

    // All requesters held: rotation from requester 0 and wrap.
    #1 apply_reset();
    @(posedge clk); #1 req = 4'b1111;
    ng = 0; cyc = 0;
    while (ng < 5 && cyc < 60) begin
      @(negedge clk);
      if (gnt != '0) begin
        g_cyc[ng] = cyc;
        g_idx[ng] = 0;
        for (int i = 0; i < int'(NREQ); i++) if (gnt[i]) g_idx[ng] = i;
        ng++;
      end
      cyc++;
    end
    chk("rr_count", 32'(ng), 32'd5);
    for (int i = 0; i < 5; i++) chk("rr_order", 32'(g_idx[i]), 32'(exp_order[i]));
    for (int i = 1; i < 5; i++) chk("rr_spacing", 32'(g_cyc[i] - g_cyc[i-1]), 32'(LAT + 2));
    @(posedge clk); #1 req = '0;
    repeat (8) @(posedge clk);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      rsp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < int'(NREQ); i++) begin
        if (req[i] && last_gnt[i]) begin
          req[i] = ($urandom_range(0, 1) == 1);
          set_op(i, 4'($urandom), 4'($urandom), 1'($urandom));
        end else if (req[i]) begin
          if ($urandom_range(0, 19) == 0) req[i] = 1'b0;
        end else if ($urandom_range(0, 9) < 3) begin
          req[i] = 1'b1;
          set_op(i, 4'($urandom), 4'($urandom), 1'($urandom));
        end
      end
    end
    @(posedge clk); #1 req = '0; rsp_ready = 1'b1;
    repeat (12) @(posedge clk);

    // Reset during HOLD discards the operation.
    #1 req = 4'b0001; set_op(0, 4'h7, 4'h7, 1'b1);
    @(negedge clk);
    chk("hr_gnt", 32'(gnt), 32'b0001);
    @(posedge clk); #1 req = '0;
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    chk("hr_busy", 32'(busy), 32'd0);
    chk("hr_valid", 32'(rsp_valid), 32'd0);
    chk("hr_gnt0", 32'(gnt), 32'd0);
    chk("hr_add", 32'({add_ci, add_b, add_a}), 32'd0);
    chk("hr_rsp", 32'({rsp_id, rsp_co, rsp_sum}), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("hr_no_rsp", 32'(rsp_valid), 32'd0);
    end
    @(posedge clk); #1 req = 4'b1010;
    @(negedge clk);
    chk("hr_first_gnt", 32'(gnt), 32'b0010);
    @(posedge clk); #1 req = '0;
    repeat (10) @(posedge clk);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, checks %0d failed %0d", n_chk, n_fail);
    $fatal(1);
  end

endmodule
